// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and Gray-code helpers for the FIFO read side.
//   ADDR_W_DEF, SYNC_STAGES_DEF, AE_THRESH_DEF : default parameter values
//   bin2gray / gray2bin : width-parametrised conversions. Values are carried
//   in MAX_W-bit containers, and bits at or above 'width' are forced to zero.
package fifo_pkg;

  localparam int ADDR_W_DEF      = 8;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int AE_THRESH_DEF   = 4;
  localparam int MAX_W           = 32;

  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b,
                                                input int width);
    logic [MAX_W-1:0] g;
    g = b ^ (b >> 1);
    for (int i = 0; i < MAX_W; i++) begin
      if (i >= width) g[i] = 1'b0;
    end
    return g;
  endfunction

  // Prefix XOR from the MSB down. Unused upper bits must be zero on entry,
  // so the top of the chain starts clean.
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g,
                                                input int width);
    logic [MAX_W-1:0] b;
    b = g;
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    for (int i = 0; i < MAX_W; i++) begin
      if (i >= width) b[i] = 1'b0;
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// fifo_rd_ctrl_if: read-side bus of the FIFO controller.
//   r_en, clr_err, w_gaddr                    : driven by the user/write side
//   r_addr, r_gaddr, r_empty, r_almost_empty,
//   r_level, r_underflow                      : driven by the controller
// slave  = controller view, master = user view.
interface fifo_rd_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic              r_en;
  logic              clr_err;
  logic [ADDR_W:0]   w_gaddr;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_gaddr;
  logic              r_empty;
  logic              r_almost_empty;
  logic [ADDR_W:0]   r_level;
  logic              r_underflow;

  modport master (
    output r_en, clr_err, w_gaddr,
    input  r_addr, r_gaddr, r_empty, r_almost_empty, r_level, r_underflow
  );

  modport slave (
    input  r_en, clr_err, w_gaddr,
    output r_addr, r_gaddr, r_empty, r_almost_empty, r_level, r_underflow
  );
endinterface

// File: rtl/sync_bus.sv
// sync_bus: STAGES-deep flop chain that brings a Gray-coded bus into clk.
//   clk, rst : clock, synchronous active-high reset (clears every stage)
//   i_d      : asynchronous input bus
//   o_q      : output of the last stage
// STAGES must be at least 2.
module sync_bus #(
  parameter int WIDTH  = 9,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < STAGES; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-side pointer and flag logic of an asynchronous FIFO.
//   r_clk, rst : read clock, synchronous active-high reset
//   bus.slave  : r_en/clr_err/w_gaddr in; r_addr, r_gaddr, r_empty,
//                r_almost_empty, r_level, r_underflow out
// The flags are computed from the next pointer value. This lets r_empty
// rise on the same edge that consumes the last word.
// w_gaddr reaches the outputs only through the synchroniser flops.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int AE_THRESH   = AE_THRESH_DEF
) (
  input  logic           r_clk,
  input  logic           rst,
  fifo_rd_ctrl_if.slave  bus
);

  localparam int PW = ADDR_W + 1;
  localparam logic [PW-1:0] AE_LVL = PW'(AE_THRESH);

  logic [PW-1:0] r_bin;
  logic [PW-1:0] w_sync;
  logic [PW-1:0] w_wbin;
  logic [PW-1:0] w_bin_next;
  logic [PW-1:0] w_gray_next;
  logic [PW-1:0] w_level_next;
  logic          w_rd_ok;

  sync_bus #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (r_clk),
    .rst (rst),
    .i_d (bus.w_gaddr),
    .o_q (w_sync)
  );

  assign w_wbin       = PW'(gray2bin(MAX_W'(w_sync), PW));
  assign w_rd_ok      = bus.r_en & ~bus.r_empty;
  assign w_bin_next   = r_bin + PW'(w_rd_ok);
  assign w_gray_next  = PW'(bin2gray(MAX_W'(w_bin_next), PW));
  assign w_level_next = w_wbin - w_bin_next;

  assign bus.r_addr = r_bin[ADDR_W-1:0];

  always_ff @(posedge r_clk) begin
    if (rst) begin
      r_bin              <= '0;
      bus.r_gaddr        <= '0;
      bus.r_empty        <= 1'b1;
      bus.r_almost_empty <= 1'b1;
      bus.r_level        <= '0;
      bus.r_underflow    <= 1'b0;
    end else begin
      r_bin              <= w_bin_next;
      bus.r_gaddr        <= w_gray_next;
      bus.r_empty        <= (w_gray_next == w_sync);
      bus.r_level        <= w_level_next;
      bus.r_almost_empty <= (w_level_next <= AE_LVL);
      // If a read-while-empty and clr_err happen in the same cycle, the set wins.
      if (bus.r_en && bus.r_empty) bus.r_underflow <= 1'b1;
      else if (bus.clr_err)        bus.r_underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
module tb_fifo_rd_ctrl;

  logic r_clk = 1'b0;
  logic rst   = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  fifo_rd_ctrl_if #(.ADDR_W(8)) bus ();

  fifo_rd_ctrl #(
    .ADDR_W      (8),
    .SYNC_STAGES (2),
    .AE_THRESH   (4)
  ) dut (
    .r_clk (r_clk),
    .rst   (rst),
    .bus   (bus.slave)
  );

  always #5 r_clk = ~r_clk;

  function automatic logic [8:0] gray9(input logic [8:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic apply_reset();
    rst = 1'b1; bus.r_en = 1'b0; bus.clr_err = 1'b0; bus.w_gaddr = '0;
    repeat (2) @(negedge r_clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++; if (bus.r_empty !== 1'b1) begin n_errors++; $display("FAIL reset_empty got %b exp 1", bus.r_empty); end
    n_checks++; if (bus.r_almost_empty !== 1'b1) begin n_errors++; $display("FAIL reset_ae got %b exp 1", bus.r_almost_empty); end
    n_checks++; if (bus.r_level !== 9'd0) begin n_errors++; $display("FAIL reset_level got %0d exp 0", bus.r_level); end
    n_checks++; if (bus.r_gaddr !== 9'h000) begin n_errors++; $display("FAIL reset_gaddr got %h exp 000", bus.r_gaddr); end
    n_checks++; if (bus.r_underflow !== 1'b0) begin n_errors++; $display("FAIL reset_uf got %b exp 0", bus.r_underflow); end
    n_checks++; if (bus.r_addr !== 8'h00) begin n_errors++; $display("FAIL reset_addr got %h exp 00", bus.r_addr); end
  endtask

  task automatic test_latency();
    apply_reset();
    bus.w_gaddr = 9'h001;
    @(negedge r_clk);
    n_checks++; if (bus.r_empty !== 1'b1) begin n_errors++; $display("FAIL lat_t1_empty got %b exp 1", bus.r_empty); end
    @(negedge r_clk);
    n_checks++; if (bus.r_empty !== 1'b1) begin n_errors++; $display("FAIL lat_t2_empty got %b exp 1", bus.r_empty); end
    n_checks++; if (bus.r_level !== 9'd0) begin n_errors++; $display("FAIL lat_t2_level got %0d exp 0", bus.r_level); end
    @(negedge r_clk);
    n_checks++; if (bus.r_empty !== 1'b0) begin n_errors++; $display("FAIL lat_t3_empty got %b exp 0", bus.r_empty); end
    n_checks++; if (bus.r_level !== 9'd1) begin n_errors++; $display("FAIL lat_t3_level got %0d exp 1", bus.r_level); end
    n_checks++; if (bus.r_almost_empty !== 1'b1) begin n_errors++; $display("FAIL lat_t3_ae got %b exp 1", bus.r_almost_empty); end
  endtask

  // Starts from the state left by test_latency: pointer 0, one word available.
  task automatic test_underflow();
    bus.r_en = 1'b1;
    @(negedge r_clk);
    n_checks++; if (bus.r_addr !== 8'd1) begin n_errors++; $display("FAIL uf_read_addr got %0d exp 1", bus.r_addr); end
    n_checks++; if (bus.r_empty !== 1'b1) begin n_errors++; $display("FAIL uf_read_empty got %b exp 1", bus.r_empty); end
    n_checks++; if (bus.r_underflow !== 1'b0) begin n_errors++; $display("FAIL uf_read_flag got %b exp 0", bus.r_underflow); end
    @(negedge r_clk);
    n_checks++; if (bus.r_underflow !== 1'b1) begin n_errors++; $display("FAIL uf_set got %b exp 1", bus.r_underflow); end
    n_checks++; if (bus.r_addr !== 8'd1) begin n_errors++; $display("FAIL uf_addr_hold got %0d exp 1", bus.r_addr); end
    bus.r_en = 1'b0; bus.clr_err = 1'b1;
    @(negedge r_clk);
    n_checks++; if (bus.r_underflow !== 1'b0) begin n_errors++; $display("FAIL uf_clear got %b exp 0", bus.r_underflow); end
    bus.r_en = 1'b1; bus.clr_err = 1'b1;
    @(negedge r_clk);
    n_checks++; if (bus.r_underflow !== 1'b1) begin n_errors++; $display("FAIL uf_set_wins got %b exp 1", bus.r_underflow); end
    bus.r_en = 1'b0; bus.clr_err = 1'b1;
    @(negedge r_clk);
    n_checks++; if (bus.r_underflow !== 1'b0) begin n_errors++; $display("FAIL uf_clear2 got %b exp 0", bus.r_underflow); end
    bus.clr_err = 1'b0;
  endtask

  task automatic test_drain();
    logic [8:0] lvl;
    apply_reset();
    bus.w_gaddr = 9'h00F;
    repeat (3) @(negedge r_clk);
    n_checks++; if (bus.r_level !== 9'd10) begin n_errors++; $display("FAIL drain_start_level got %0d exp 10", bus.r_level); end
    n_checks++; if (bus.r_almost_empty !== 1'b0) begin n_errors++; $display("FAIL drain_start_ae got %b exp 0", bus.r_almost_empty); end
    n_checks++; if (bus.r_addr !== 8'd0) begin n_errors++; $display("FAIL drain_start_addr got %0d exp 0", bus.r_addr); end
    bus.r_en = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge r_clk);
      lvl = 9'(10 - k);
      n_checks++; if (bus.r_addr !== 8'(k)) begin n_errors++; $display("FAIL drain_addr[%0d] got %0d exp %0d", k, bus.r_addr, k); end
      n_checks++; if (bus.r_level !== lvl) begin n_errors++; $display("FAIL drain_level[%0d] got %0d exp %0d", k, bus.r_level, lvl); end
      n_checks++; if (bus.r_almost_empty !== (lvl <= 9'd4)) begin n_errors++; $display("FAIL drain_ae[%0d] got %b exp %b", k, bus.r_almost_empty, (lvl <= 9'd4)); end
      n_checks++; if (bus.r_empty !== (k == 10)) begin n_errors++; $display("FAIL drain_empty[%0d] got %b exp %b", k, bus.r_empty, (k == 10)); end
    end
    @(negedge r_clk);
    n_checks++; if (bus.r_addr !== 8'd10) begin n_errors++; $display("FAIL drain_hold_addr got %0d exp 10", bus.r_addr); end
    n_checks++; if (bus.r_underflow !== 1'b1) begin n_errors++; $display("FAIL drain_over_uf got %b exp 1", bus.r_underflow); end
    bus.r_en = 1'b0; bus.clr_err = 1'b1;
    @(negedge r_clk);
    bus.clr_err = 1'b0;
  endtask

  task automatic drain_until_empty(input string tag);
    bit done = 0;
    bus.r_en = 1'b1;
    for (int i = 0; i < 600 && !done; i++) begin
      @(negedge r_clk);
      if (bus.r_empty) begin bus.r_en = 1'b0; done = 1; end
    end
    bus.r_en = 1'b0;
    n_checks++; if (!done) begin n_errors++; $display("FAIL %s_timeout got not-empty exp empty within 600 cycles", tag); end
  endtask

  task automatic test_wrap();
    apply_reset();
    bus.w_gaddr = gray9(9'd255);
    repeat (3) @(negedge r_clk);
    drain_until_empty("wrap_a");
    n_checks++; if (bus.r_gaddr !== 9'h080) begin n_errors++; $display("FAIL wrap_a_gaddr got %h exp 080", bus.r_gaddr); end
    bus.w_gaddr = gray9(9'd511);
    repeat (3) @(negedge r_clk);
    n_checks++; if (bus.r_level !== 9'd256) begin n_errors++; $display("FAIL wrap_b_level got %0d exp 256", bus.r_level); end
    drain_until_empty("wrap_b");
    n_checks++; if (bus.r_addr !== 8'hFF) begin n_errors++; $display("FAIL wrap_pre_addr got %h exp ff", bus.r_addr); end
    n_checks++; if (bus.r_gaddr !== 9'h100) begin n_errors++; $display("FAIL wrap_pre_gaddr got %h exp 100", bus.r_gaddr); end
    bus.w_gaddr = 9'h000;
    repeat (3) @(negedge r_clk);
    n_checks++; if (bus.r_level !== 9'd1) begin n_errors++; $display("FAIL wrap_avail_level got %0d exp 1", bus.r_level); end
    n_checks++; if (bus.r_empty !== 1'b0) begin n_errors++; $display("FAIL wrap_avail_empty got %b exp 0", bus.r_empty); end
    bus.r_en = 1'b1;
    @(negedge r_clk);
    bus.r_en = 1'b0;
    n_checks++; if (bus.r_addr !== 8'h00) begin n_errors++; $display("FAIL wrap_addr got %h exp 00", bus.r_addr); end
    n_checks++; if (bus.r_gaddr !== 9'h000) begin n_errors++; $display("FAIL wrap_gaddr got %h exp 000", bus.r_gaddr); end
    n_checks++; if (bus.r_empty !== 1'b1) begin n_errors++; $display("FAIL wrap_empty got %b exp 1", bus.r_empty); end
    n_checks++; if (bus.r_level !== 9'd0) begin n_errors++; $display("FAIL wrap_level got %0d exp 0", bus.r_level); end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    bus.w_gaddr = gray9(9'd7);
    repeat (3) @(negedge r_clk);
    bus.r_en = 1'b1;
    repeat (2) @(negedge r_clk);
    bus.r_en = 1'b0;
    n_checks++; if (bus.r_level !== 9'd5) begin n_errors++; $display("FAIL mid_pre_level got %0d exp 5", bus.r_level); end
    n_checks++; if (bus.r_addr !== 8'd2) begin n_errors++; $display("FAIL mid_pre_addr got %0d exp 2", bus.r_addr); end
    rst = 1'b1; bus.r_en = 1'b1; bus.w_gaddr = 9'h000;
    @(negedge r_clk);
    rst = 1'b0; bus.r_en = 1'b0;
    n_checks++; if (bus.r_addr !== 8'd0) begin n_errors++; $display("FAIL mid_addr got %0d exp 0", bus.r_addr); end
    n_checks++; if (bus.r_gaddr !== 9'h000) begin n_errors++; $display("FAIL mid_gaddr got %h exp 000", bus.r_gaddr); end
    n_checks++; if (bus.r_empty !== 1'b1) begin n_errors++; $display("FAIL mid_empty got %b exp 1", bus.r_empty); end
    n_checks++; if (bus.r_almost_empty !== 1'b1) begin n_errors++; $display("FAIL mid_ae got %b exp 1", bus.r_almost_empty); end
    n_checks++; if (bus.r_level !== 9'd0) begin n_errors++; $display("FAIL mid_level got %0d exp 0", bus.r_level); end
    n_checks++; if (bus.r_underflow !== 1'b0) begin n_errors++; $display("FAIL mid_uf got %b exp 0", bus.r_underflow); end
    @(negedge r_clk);
    n_checks++; if (bus.r_empty !== 1'b1) begin n_errors++; $display("FAIL mid_sync_cleared_empty got %b exp 1", bus.r_empty); end
    n_checks++; if (bus.r_level !== 9'd0) begin n_errors++; $display("FAIL mid_sync_cleared_level got %0d exp 0", bus.r_level); end
  endtask

  initial begin
    bus.r_en = 1'b0; bus.clr_err = 1'b0; bus.w_gaddr = '0;
    test_reset();
    test_latency();
    test_underflow();
    test_drain();
    test_wrap();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
